// File: rtl/var_delay_pkg.sv
// Shared types for the variable delay line: request kinds, safe-update FSM
// states and the length-width helper.
package var_delay_pkg;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_SET,
        REQ_INC,
        REQ_DEC
    } req_kind_t;

    typedef enum logic {
        ST_RUN,
        ST_PEND
    } state_t;

    // Bits needed to hold every value 0..max_val inclusive.
    function automatic int len_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/var_delay_line_if.sv
// Bundle between the SPI-side drivers and the variable delay line.
interface var_delay_line_if
    import var_delay_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 15
);
    localparam int LEN_W = len_width(DEPTH);

    // Handshake: inc_pulse, dec_pulse and set_valid are single-cycle strobes
    // sampled on every rising clk edge. There is no ready; a request is always
    // accepted in the cycle it is presented and either applied at that edge or
    // folded into the pending target.
    logic [WIDTH-1:0] in_sig;
    logic             inc_pulse;
    logic             dec_pulse;
    logic             set_valid;
    logic [LEN_W-1:0] set_len;
    logic [WIDTH-1:0] out_sig;
    logic [LEN_W-1:0] len_o;
    logic             pending_o;
    state_t           state_dbg;

    modport master (
        output in_sig,
        output inc_pulse,
        output dec_pulse,
        output set_valid,
        output set_len,
        input  out_sig,
        input  len_o,
        input  pending_o,
        input  state_dbg
    );

    modport slave (
        input  in_sig,
        input  inc_pulse,
        input  dec_pulse,
        input  set_valid,
        input  set_len,
        output out_sig,
        output len_o,
        output pending_o,
        output state_dbg
    );

endinterface

// File: rtl/var_delay_tap.sv
// One channel of the delay line: a DEPTH-stage shift register that always
// shifts, plus a mux selecting stage len-1 (or the live input when len is 0).
module var_delay_tap #(
    parameter int DEPTH = 15,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic [LEN_W-1:0] len,
    output logic             q
);

    logic [DEPTH-1:0] pipe;

    if (DEPTH == 1) begin : g_one
        always_ff @(posedge clk) begin
            if (rst) begin
                pipe <= '0;
            end else begin
                pipe <= d;
            end
        end
    end else begin : g_many
        always_ff @(posedge clk) begin
            if (rst) begin
                pipe <= '0;
            end else begin
                pipe <= {pipe[DEPTH-2:0], d};
            end
        end
    end

    // Stage i holds the input from i+1 cycles ago, so len selects stage len-1.
    always_comb begin
        q = d;
        for (int i = 0; i < DEPTH; i++) begin
            if (len == LEN_W'(i + 1)) begin
                q = pipe[i];
            end
        end
    end

endmodule

// File: rtl/var_delay_line.sv
// Multi-channel variable delay line with inc/dec/set length control.
// Define VAR_DELAY_SAFE_UPDATE_EN to defer length changes until IDLE_CH idles.
module var_delay_line
    import var_delay_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int DEPTH      = 15,
    parameter bit WRAP       = 1'b1,
    parameter int IDLE_CH    = 0,
    parameter bit IDLE_LEVEL = 1'b1,
    parameter int IDLE_CYC   = DEPTH
) (
    input logic             clk,
    input logic             rst,
    var_delay_line_if.slave bus
);

    localparam int               LEN_W   = len_width(DEPTH);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] base_len;
    logic [LEN_W-1:0] resolved_len;
    logic [WIDTH-1:0] out_bits;
    req_kind_t        req_kind;
    logic             req_valid;

    // Absolute load wins; opposing inc and dec in one cycle cancel.
    always_comb begin
        req_kind = REQ_NONE;
        if (bus.set_valid) begin
            req_kind = REQ_SET;
        end else if (bus.inc_pulse && !bus.dec_pulse) begin
            req_kind = REQ_INC;
        end else if (bus.dec_pulse && !bus.inc_pulse) begin
            req_kind = REQ_DEC;
        end
    end

    assign req_valid = (req_kind != REQ_NONE);

    always_comb begin
        resolved_len = base_len;
        case (req_kind)
            REQ_SET: begin
                resolved_len = (bus.set_len > MAX_LEN) ? MAX_LEN : bus.set_len;
            end
            REQ_INC: begin
                if (base_len >= MAX_LEN) begin
                    resolved_len = WRAP ? '0 : MAX_LEN;
                end else begin
                    resolved_len = base_len + 1'b1;
                end
            end
            REQ_DEC: begin
                if (base_len == '0) begin
                    resolved_len = WRAP ? MAX_LEN : '0;
                end else begin
                    resolved_len = base_len - 1'b1;
                end
            end
            default: begin
                resolved_len = base_len;
            end
        endcase
    end

`ifdef VAR_DELAY_SAFE_UPDATE_EN
    localparam int               CNT_W   = len_width(IDLE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_CYC);

    logic [CNT_W-1:0] idle_cnt;
    logic             idle_now;
    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] target_q;
    logic [LEN_W-1:0] target_d;
    logic [LEN_W-1:0] len_d;

    assign idle_now = (bus.in_sig[IDLE_CH] == IDLE_LEVEL);

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (!idle_now) begin
            idle_cnt <= '0;
        end else if (idle_cnt != CNT_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            target_q <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            len_q    <= len_d;
        end
    end

    // A request in the same cycle as the idle condition holds off the apply,
    // so the target is always settled for at least one idle edge.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        len_d    = len_q;
        case (state_q)
            ST_RUN: begin
                if (req_valid) begin
                    state_d  = ST_PEND;
                    target_d = resolved_len;
                end
            end
            ST_PEND: begin
                if (req_valid) begin
                    target_d = resolved_len;
                end else if (idle_cnt == CNT_MAX) begin
                    state_d = ST_RUN;
                    len_d   = target_q;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign base_len      = (state_q == ST_PEND) ? target_q : len_q;
    assign bus.pending_o = (state_q == ST_PEND);
    assign bus.state_dbg = state_q;
`else
    logic unused_idle_cfg;

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q <= '0;
        end else if (req_valid) begin
            len_q <= resolved_len;
        end
    end

    assign base_len        = len_q;
    assign bus.pending_o   = 1'b0;
    assign bus.state_dbg   = ST_RUN;
    assign unused_idle_cfg = IDLE_LEVEL ^ (IDLE_CH < 0) ^ (IDLE_CYC < 1);
`endif

    for (genvar c = 0; c < WIDTH; c++) begin : g_tap
        var_delay_tap #(
            .DEPTH(DEPTH),
            .LEN_W(LEN_W)
        ) u_tap (
            .clk(clk),
            .rst(rst),
            .d  (bus.in_sig[c]),
            .len(len_q),
            .q  (out_bits[c])
        );
    end

    assign bus.out_sig = out_bits;
    assign bus.len_o   = len_q;

endmodule
